viterbi_acs_sequencer: RTL and testbench
========================================

// Module: viterbi_acs_sequencer
// PURPOSE
//  Frame-level controller for the rate-1/2, K=3 (4-state) Viterbi decoder. It accepts
//  received soft symbol pairs and issues one ACS trellis step per pair to the external
//  add-compare-select datapath. It owns the 4 path metrics and normalises them, stores
//  the survivor decisions, and runs traceback to emit one decoded word per frame.
// PARAMETERS
//  FRAME_LEN  16      trellis steps per frame (decoded bits per word), 2..64
//  W          8       width of soft symbols and path metrics (signed)
//  PM_INIT    64      initial metric for states 01/10/11; state 00 starts at 0
//  NORM_THR   64      normalisation threshold and subtrahend
// PORTS
//  CLK        in   1            rising-edge clock
//  RST        in   1            synchronous, active-high reset
//  sym_valid  in   1            symbol pair valid
//  sym_ready  out  1            controller can accept a pair
//  r0, r1     in   W            signed soft symbols of the pair
//  acs_go     out  1            one-cycle start strobe to the ACS datapath
//  acs_r0/r1  out  W            held symbol pair for the ACS datapath
//  acs_pm     out  4*W          current metrics, {pm11,pm10,pm01,pm00}
//  acs_done   in   1            ACS result valid (single-cycle pulse)
//  acs_pm_new in   4*W          new metrics, same packing as acs_pm
//  acs_dec    in   4            decision bit per new state; bit s selects the predecessor of s
//  dec_valid  out  1            one-cycle pulse: dec_word valid
//  dec_word   out  FRAME_LEN    decoded bits; bit t = input bit at trellis step t
//  acs_err    out  1            sticky flag: acs_done seen outside WAIT; cleared only by RST
// BEHAVIOUR
//  Reset: state=IDLE. sym_ready, acs_go, dec_valid and acs_err are 0. acs_r0/r1=0,
//   dec_word=0, step counter=0, pm={PM_INIT,PM_INIT,PM_INIT,0}. The decision buffer
//   is not cleared. All outputs are registered.
//  RST asserted in any state, including mid-frame or mid-traceback, aborts the frame.
//   The partial frame is discarded; no dec_valid is produced.
//  FSM states:
//   IDLE   -> LOAD at the cycle after reset deassertion.
//   LOAD   sym_ready=1. On sym_valid&&sym_ready: latch r0,r1 into acs_r0/r1, go to ISSUE.
//   ISSUE  acs_go=1 for exactly this cycle; -> WAIT.
//   WAIT   Hold acs_r0/r1 and acs_pm stable. On acs_done -> UPDATE (latch acs_pm_new and
//          acs_dec). No timeout.
//   UPDATE Write acs_dec to dec_buf[step]. pm <= latched new metrics, normalised:
//          if every pm >= NORM_THR (signed), subtract NORM_THR from all four. If
//          step==FRAME_LEN-1 -> TRACE, else step++ and -> LOAD.
//   TRACE  Initial state = index of minimum pm, lowest index on ties. Each cycle, for
//          t=FRAME_LEN-1 down to 0: bit t = s[1]; s <= {s[0], dec_buf[t][s]}.
//          Takes FRAME_LEN cycles, then -> OUT.
//   OUT    dec_valid=1 for one cycle with dec_word. pm is re-initialised to the reset
//          value, step=0; -> LOAD.
//  Trellis convention: state s={s1,s0}, s1 = newest input bit; next state = {u,s1}.
//  Per-symbol occupancy: 1 (accept) + 1 (ISSUE) + ACS latency + 1 (UPDATE) cycles.
//   sym_ready is 0 from the accept edge until the controller re-enters LOAD.
//  Frame latency: last accept -> dec_valid = ISSUE+WAIT+UPDATE+FRAME_LEN+1 cycles.
//  An acs_done pulse outside WAIT is ignored and sets acs_err.
//   An acs_done in the same cycle as acs_go (ISSUE) counts as outside WAIT.
//  Metric arithmetic: W-bit signed, no saturation. Normalisation bounds the spread,
//   provided the datapath's branch metric is at most 2^(W-2).
// STRUCTURE
//  Shared package viterbi_pkg:
//   - state encodings (S00..S11) and FSM state enum
//   - PM_INIT and NORM_THR defaults
//   - pm pack/unpack macros for the {pm11,pm10,pm01,pm00} bus
//  One sub-module: viterbi_tb_mem
//   - FRAME_LEN x 4 decision register file
//   - one synchronous write port (UPDATE), one combinational read port (TRACE)
//  The FSM, normalisation, min-select and traceback shifter live in this module.
// TESTING
//  1. Reset, then hold sym_valid=0 for 10 cycles -> sym_ready=1 from cycle 2; acs_go never
//     pulses; pm=={64,64,64,0}.
//  2. Behavioural ACS model with 2-cycle latency; encode 16 bits 1011_0010_1110_0001 as
//     hard symbols +/-100 -> one dec_valid, dec_word==16'hB2E1, acs_err==0.
//  3. Same stream with 3 symbols sign-inverted -> dec_word still 16'hB2E1
//     (free-distance-5 code corrects isolated errors).
//  4. Model returns metrics {70,80,90,100} -> next acs_pm=={6,16,26,36};
//     {60,80,90,100} -> unchanged.
//  5. Assert RST during WAIT of step 7 -> next cycle IDLE, acs_go=0, pm reinit;
//     a following full frame decodes correctly with no dec_valid for the aborted frame.
//  6. Pulse acs_done in LOAD -> acs_err=1 and stays 1; FSM stays in LOAD; the next frame
//     still decodes correctly.

Source files
------------

// File: rtl/viterbi_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | viterbi_pkg : shared types and constants for the K=3 Viterbi control  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`ifndef VITERBI_PKG_MACROS
`define VITERBI_PKG_MACROS
`define VIT_PM_GET(bus, s, w) bus[(s)*(w) +: (w)]
`define VIT_PM_PACK(p) {p[3], p[2], p[1], p[0]}
`endif

package viterbi_pkg;

  localparam int PM_INIT_DEF  = 64;
  localparam int NORM_THR_DEF = 64;

  typedef enum logic [1:0] {
    S00 = 2'd0,
    S01 = 2'd1,
    S10 = 2'd2,
    S11 = 2'd3
  } trellis_state_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_TRACE  = 3'd5,
    ST_OUT    = 3'd6
  } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/viterbi_tb_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | viterbi_tb_mem : survivor decision store, sync write / async read     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module viterbi_tb_mem
  import viterbi_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [3:0]    rdata
);

  logic [3:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/viterbi_acs_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | viterbi_acs_sequencer : frame controller, metric owner and traceback  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module viterbi_acs_sequencer
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int W         = 8,
  parameter int PM_INIT   = PM_INIT_DEF,
  parameter int NORM_THR  = NORM_THR_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 sym_valid,
  output logic                 sym_ready,
  input  logic signed [W-1:0]  r0,
  input  logic signed [W-1:0]  r1,
  output logic                 acs_go,
  output logic signed [W-1:0]  acs_r0,
  output logic signed [W-1:0]  acs_r1,
  output logic [4*W-1:0]       acs_pm,
  input  logic                 acs_done,
  input  logic [4*W-1:0]       acs_pm_new,
  input  logic [3:0]           acs_dec,
  output logic                 dec_valid,
  output logic [FRAME_LEN-1:0] dec_word,
  output logic                 acs_err
);

  localparam int SW = $clog2(FRAME_LEN);
  localparam logic [SW-1:0]       LAST      = SW'(FRAME_LEN - 1);
  localparam logic signed [W-1:0] PM_INIT_V = W'(PM_INIT);
  localparam logic signed [W-1:0] THR       = W'(NORM_THR);

  fsm_state_t            state, state_nxt;
  logic [SW-1:0]         step;
  logic signed [W-1:0]   pm      [4];
  logic signed [W-1:0]   pm_lat  [4];
  logic signed [W-1:0]   pm_norm [4];
  logic [3:0]            dec_lat;
  logic [3:0]            rd_dec;
  logic                  all_ge;
  trellis_state_t        tr_s, min_s;

  viterbi_tb_mem #(.DEPTH(FRAME_LEN), .AW(SW)) u_mem (
    .clk   (CLK),
    .we    (state == ST_UPDATE),
    .waddr (step),
    .wdata (dec_lat),
    .raddr (step),
    .rdata (rd_dec)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = ST_LOAD;
      ST_LOAD:   if (sym_valid && sym_ready) state_nxt = ST_ISSUE;
      ST_ISSUE:  state_nxt = ST_WAIT;
      ST_WAIT:   if (acs_done) state_nxt = ST_UPDATE;
      ST_UPDATE: state_nxt = (step == LAST) ? ST_TRACE : ST_LOAD;
      ST_TRACE:  if (step == '0) state_nxt = ST_OUT;
      ST_OUT:    state_nxt = ST_LOAD;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Normalise only when every metric clears the threshold; argmin keeps the lowest index on ties.
  always_comb begin
    all_ge = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (pm_lat[i] < THR) all_ge = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      pm_norm[i] = all_ge ? (pm_lat[i] - THR) : pm_lat[i];
    end
    min_s = S00;
    for (int i = 1; i < 4; i++) begin
      if (pm_norm[i] < pm_norm[min_s]) min_s = trellis_state_t'(2'(i));
    end
  end

  assign acs_pm = `VIT_PM_PACK(pm);

  always_ff @(posedge CLK) begin
    if (RST) begin
      sym_ready <= 1'b0;
      acs_go    <= 1'b0;
      dec_valid <= 1'b0;
      acs_err   <= 1'b0;
      acs_r0    <= '0;
      acs_r1    <= '0;
      dec_word  <= '0;
      step      <= '0;
      dec_lat   <= '0;
      tr_s      <= S00;
      for (int i = 0; i < 4; i++) begin
        pm[i]     <= (i == 0) ? '0 : PM_INIT_V;
        pm_lat[i] <= (i == 0) ? '0 : PM_INIT_V;
      end
    end else begin
      sym_ready <= (state_nxt == ST_LOAD);
      acs_go    <= (state_nxt == ST_ISSUE);
      dec_valid <= (state_nxt == ST_OUT);
      if (acs_done && state != ST_WAIT) acs_err <= 1'b1;
      case (state)
        ST_LOAD: begin
          if (sym_valid && sym_ready) begin
            acs_r0 <= r0;
            acs_r1 <= r1;
          end
        end
        ST_WAIT: begin
          if (acs_done) begin
            for (int i = 0; i < 4; i++) pm_lat[i] <= `VIT_PM_GET(acs_pm_new, i, W);
            dec_lat <= acs_dec;
          end
        end
        ST_UPDATE: begin
          for (int i = 0; i < 4; i++) pm[i] <= pm_norm[i];
          if (step == LAST) tr_s <= min_s;
          else              step <= step + 1'b1;
        end
        ST_TRACE: begin
          // Predecessor of {a,b} is {b,d}: shift the stored decision in as the older bit.
          dec_word[step] <= tr_s[1];
          tr_s           <= trellis_state_t'({tr_s[0], rd_dec[tr_s]});
          if (step != '0) step <= step - 1'b1;
        end
        ST_OUT: begin
          step <= '0;
          for (int i = 0; i < 4; i++) pm[i] <= (i == 0) ? '0 : PM_INIT_V;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_viterbi_acs_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_viterbi_acs_sequencer : directed bench with behavioural ACS model  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_viterbi_acs_sequencer;

  localparam logic [31:0] PM_RST = 32'h4040_4000;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              sym_valid = 1'b0;
  logic              sym_ready;
  logic signed [7:0] r0 = '0;
  logic signed [7:0] r1 = '0;
  logic              acs_go;
  logic signed [7:0] acs_r0, acs_r1;
  logic [31:0]       acs_pm;
  logic              acs_done = 1'b0;
  logic [31:0]       acs_pm_new = '0;
  logic [3:0]        acs_dec = '0;
  logic              dec_valid;
  logic [15:0]       dec_word;
  logic              acs_err;

  int errors = 0;
  int checks = 0;
  int dv_count = 0;

  viterbi_acs_sequencer #(.FRAME_LEN(16), .W(8), .PM_INIT(64), .NORM_THR(64)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .r0         (r0),
    .r1         (r1),
    .acs_go     (acs_go),
    .acs_r0     (acs_r0),
    .acs_r1     (acs_r1),
    .acs_pm     (acs_pm),
    .acs_done   (acs_done),
    .acs_pm_new (acs_pm_new),
    .acs_dec    (acs_dec),
    .dec_valid  (dec_valid),
    .dec_word   (dec_word),
    .acs_err    (acs_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (dec_valid === 1'b1) dv_count++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hard-decision ACS for the (7,5) code; bit 1 maps to a negative symbol.
  function automatic void acs_model(input logic [31:0] pmb, input logic signed [7:0] a,
                                    input logic signed [7:0] b,
                                    output logic [31:0] nb, output logic [3:0] d);
    logic h0, h1, u, c0, c1;
    logic [1:0] ps;
    logic signed [7:0] m [2];
    h0 = (a < 0);
    h1 = (b < 0);
    nb = '0;
    d  = '0;
    for (int s = 0; s < 4; s++) begin
      u = s[1];
      for (int x = 0; x < 2; x++) begin
        ps   = {s[0], x[0]};
        c0   = u ^ ps[1] ^ ps[0];
        c1   = u ^ ps[0];
        m[x] = pmb[int'(ps)*8 +: 8] + 8'(c0 != h0) + 8'(c1 != h1);
      end
      d[s] = (m[1] < m[0]);
      nb[s*8 +: 8] = d[s] ? m[1] : m[0];
    end
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (sym_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("sym_ready_wait", sym_ready, 1'b1);
  endtask

  task automatic send_pair(input logic signed [7:0] a, input logic signed [7:0] b,
                           input bit forced, input logic [31:0] fpm, input bit abort);
    logic [31:0] nb;
    logic [3:0]  d;
    wait_ready();
    r0 = a;
    r1 = b;
    sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
    check("acs_go_issue", acs_go, 1'b1);
    check("ready_low_issue", sym_ready, 1'b0);
    check("acs_r0_held", acs_r0, a);
    check("acs_r1_held", acs_r1, b);
    if (forced) begin
      nb = fpm;
      d  = '0;
    end else begin
      acs_model(acs_pm, a, b, nb, d);
    end
    tick();
    check("acs_go_one_cycle", acs_go, 1'b0);
    if (abort) begin
      RST = 1'b1;
      tick();
      check("abort_go", acs_go, 1'b0);
      check("abort_ready", sym_ready, 1'b0);
      check("abort_pm", acs_pm, PM_RST);
      check("abort_dv", dec_valid, 1'b0);
      RST = 1'b0;
      return;
    end
    tick();
    acs_done   = 1'b1;
    acs_pm_new = nb;
    acs_dec    = d;
    tick();
    acs_done   = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] word, input logic [15:0] inv0,
                           input logic [15:0] inv1, input int abort_at, input bit err_exp);
    logic [1:0] enc;
    logic u, c0, c1;
    logic signed [7:0] a, b;
    int n;
    int dv0;
    enc = 2'b00;
    dv0 = dv_count;
    for (int t = 0; t < 16; t++) begin
      u   = word[t];
      c0  = u ^ enc[1] ^ enc[0];
      c1  = u ^ enc[0];
      enc = {u, enc[1]};
      a = c0 ? -8'sd100 : 8'sd100;
      b = c1 ? -8'sd100 : 8'sd100;
      if (inv0[t]) a = -a;
      if (inv1[t]) b = -b;
      send_pair(a, b, 1'b0, '0, t == abort_at);
      if (t == abort_at) return;
    end
    n = 0;
    while (dec_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("frame_latency", n, 17);
    check("dec_word", dec_word, word);
    check("acs_err_frame", acs_err, err_exp);
    tick();
    check("dec_valid_pulse", dec_valid, 1'b0);
    check("pm_reinit_out", acs_pm, PM_RST);
    check("ready_after_out", sym_ready, 1'b1);
    check("dec_valid_count", dv_count - dv0, 1);
  endtask

  initial begin
    logic go_seen;
    int   dv_abort;

    // Reset values and idle behaviour
    repeat (3) tick();
    check("rst_sym_ready", sym_ready, 1'b0);
    check("rst_acs_go", acs_go, 1'b0);
    check("rst_dec_valid", dec_valid, 1'b0);
    check("rst_acs_err", acs_err, 1'b0);
    check("rst_pm", acs_pm, PM_RST);
    check("rst_dec_word", dec_word, 16'h0000);
    check("rst_acs_r0", acs_r0, 8'h00);
    RST = 1'b0;
    tick();
    check("ready_after_rst", sym_ready, 1'b1);
    go_seen = 1'b0;
    repeat (10) begin
      tick();
      if (acs_go !== 1'b0) go_seen = 1'b1;
    end
    check("idle_no_go", go_seen, 1'b0);
    check("idle_ready", sym_ready, 1'b1);
    check("idle_pm", acs_pm, PM_RST);

    // Clean frame
    run_frame(16'hB2E1, 16'h0000, 16'h0000, -1, 1'b0);

    // Isolated symbol errors at steps 1, 5 and 9
    run_frame(16'hB2E1, 16'h0202, 16'h0020, -1, 1'b0);

    // Normalisation boundaries with forced metrics
    send_pair(8'sd100, 8'sd100, 1'b1, {8'd70, 8'd80, 8'd90, 8'd100}, 1'b0);
    tick();
    check("norm_all_above", acs_pm, {8'd6, 8'd16, 8'd26, 8'd36});
    send_pair(8'sd100, 8'sd100, 1'b1, {8'd60, 8'd80, 8'd90, 8'd100}, 1'b0);
    tick();
    check("norm_one_below", acs_pm, {8'd60, 8'd80, 8'd90, 8'd100});
    send_pair(8'sd100, 8'sd100, 1'b1, {8'd64, 8'd64, 8'd64, 8'd64}, 1'b0);
    tick();
    check("norm_at_thr", acs_pm, 32'h0000_0000);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("pm_after_rst", acs_pm, PM_RST);

    // Abort during WAIT of step 7, then a full frame
    dv_abort = dv_count;
    run_frame(16'hFFFF, 16'h0000, 16'h0000, 7, 1'b0);
    run_frame(16'h1D4B, 16'h0000, 16'h0000, -1, 1'b0);
    check("abort_no_dv", dv_count - dv_abort, 1);

    // Stray acs_done in LOAD
    wait_ready();
    acs_done = 1'b1;
    tick();
    acs_done = 1'b0;
    check("stray_err_set", acs_err, 1'b1);
    check("stray_stays_load", sym_ready, 1'b1);
    check("stray_no_go", acs_go, 1'b0);
    tick();
    check("stray_err_sticky", acs_err, 1'b1);
    run_frame(16'hB2E1, 16'h0000, 16'h0000, -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
